// File: rtl/kfpga_sb_pkg.sv
// Shared sizing and config-field layout helpers for the kfpga switch box.
// Every bit position in the config image is computed from these functions.
package kfpga_sb_pkg;

    localparam int unsigned NUM_SIDES = 4;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) r = r + 1;
        return r;
    endfunction

    function automatic int unsigned sb_sel_width(input int unsigned num_les);
        return clog2(3 + num_les);
    endfunction

    function automatic int unsigned le_sel_width(input int unsigned chan_w, input int unsigned num_les);
        return clog2(4 * chan_w + num_les);
    endfunction

    function automatic int unsigned config_width(input int unsigned chan_w, input int unsigned num_les,
                                                 input int unsigned le_inputs);
        return 4 * chan_w * (sb_sel_width(num_les) + 1) + num_les * le_inputs * le_sel_width(chan_w, num_les);
    endfunction

    // Side order is north, east, south, west (0..3).
    function automatic int unsigned trk_sel_off(input int unsigned chan_w, input int unsigned num_les,
                                                input int unsigned side, input int unsigned trk);
        return (side * chan_w + trk) * sb_sel_width(num_les);
    endfunction

    function automatic int unsigned mode_off(input int unsigned chan_w, input int unsigned num_les,
                                             input int unsigned side, input int unsigned trk);
        return NUM_SIDES * chan_w * sb_sel_width(num_les) + side * chan_w + trk;
    endfunction

    function automatic int unsigned le_sel_off(input int unsigned chan_w, input int unsigned num_les,
                                               input int unsigned le_inputs, input int unsigned le,
                                               input int unsigned pin);
        return NUM_SIDES * chan_w * (sb_sel_width(num_les) + 1)
               + (le * le_inputs + pin) * le_sel_width(chan_w, num_les);
    endfunction

endpackage

// File: rtl/sb_track_mux.sv
// N-input single-bit multiplexer; any select value at or above N yields 0.
module sb_track_mux #(
    parameter int unsigned N     = 5,
    parameter int unsigned SEL_W = 3
) (
    input  logic [N-1:0]     data,
    input  logic [SEL_W-1:0] sel,
    output logic             y_c
);

    logic [N-1:0] hit_c;

    for (genvar k = 0; k < N; k++) begin : g_hit
        assign hit_c[k] = (32'(sel) == 32'(k)) & data[k];
    end

    assign y_c = |hit_c;

endmodule

// File: rtl/switch_box_cfg.sv
// Wilton switch box with serial config chain, optional per-track output flops
// and output isolation until a complete bitstream is resident.
module switch_box_cfg
    import kfpga_sb_pkg::*;
#(
    parameter int unsigned CHANNEL_WIDTH = 6,
    parameter int unsigned NUM_LES       = 2,
    parameter int unsigned LE_INPUTS     = 4
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [CHANNEL_WIDTH-1:0]       data_north_in,
    input  logic [CHANNEL_WIDTH-1:0]       data_east_in,
    input  logic [CHANNEL_WIDTH-1:0]       data_south_in,
    input  logic [CHANNEL_WIDTH-1:0]       data_west_in,
    output logic [CHANNEL_WIDTH-1:0]       data_north_out,
    output logic [CHANNEL_WIDTH-1:0]       data_east_out,
    output logic [CHANNEL_WIDTH-1:0]       data_south_out,
    output logic [CHANNEL_WIDTH-1:0]       data_west_out,
    input  logic [NUM_LES-1:0]             data_from_les,
    output logic [NUM_LES*LE_INPUTS-1:0]   data_to_les,
    input  logic                           config_in,
    input  logic                           config_enable,
    output logic                           config_out,
    output logic                           config_valid
);

    localparam int unsigned W            = CHANNEL_WIDTH;
    localparam int unsigned SB_SEL       = sb_sel_width(NUM_LES);
    localparam int unsigned LE_SEL       = le_sel_width(W, NUM_LES);
    localparam int unsigned CONFIG_WIDTH = config_width(W, NUM_LES, LE_INPUTS);
    localparam int unsigned CNT_W        = clog2(CONFIG_WIDTH + 1);
    localparam int unsigned TRK_N        = NUM_LES + 3;
    localparam int unsigned LE_N         = 4 * W + NUM_LES;
    localparam int unsigned LE_PINS      = NUM_LES * LE_INPUTS;

    logic [CONFIG_WIDTH-1:0] cfg;
    logic [CNT_W-1:0]        cnt;
    logic [3:0][W-1:0]       a_c, b_c, c_c;
    logic [3:0][W-1:0]       trk_mux_c, trk_out_c;
    logic [3:0][W-1:0]       trk_q;
    logic [LE_N-1:0]         le_bus_c;
    logic [LE_PINS-1:0]      le_mux_c;

    // Config shift chain, saturating load counter and registered-track flops.
    always_ff @(posedge clock) begin
        if (reset) begin
            cfg   <= '0;
            cnt   <= '0;
            trk_q <= '0;
        end else begin
            if (config_enable) begin
                cfg <= {cfg[CONFIG_WIDTH-2:0], config_in};
                if (cnt != CNT_W'(CONFIG_WIDTH)) cnt <= cnt + CNT_W'(1);
            end
            trk_q <= config_valid ? trk_mux_c : '0;
        end
    end

    assign config_out   = cfg[CONFIG_WIDTH-1];
    assign config_valid = (cnt == CNT_W'(CONFIG_WIDTH)) && !config_enable;

    // Wilton track permutation: A/B/C sources per outgoing side and track.
    for (genvar i = 0; i < W; i++) begin : g_wilton
        assign a_c[0][i] = data_west_in[(i + 1) % W];
        assign b_c[0][i] = data_south_in[i];
        assign c_c[0][i] = data_east_in[(W - i) % W];

        assign a_c[1][i] = data_north_in[(W - i) % W];
        assign b_c[1][i] = data_west_in[i];
        assign c_c[1][i] = data_south_in[(i + 1) % W];

        assign a_c[2][i] = data_east_in[(i + 1) % W];
        assign b_c[2][i] = data_north_in[i];
        assign c_c[2][i] = data_west_in[(2 * W - 2 - i) % W];

        assign a_c[3][i] = data_south_in[(2 * W - 2 - i) % W];
        assign b_c[3][i] = data_east_in[i];
        assign c_c[3][i] = data_north_in[(i + 1) % W];
    end

    for (genvar s = 0; s < 4; s++) begin : g_side
        for (genvar i = 0; i < W; i++) begin : g_trk
            localparam int unsigned SOFF = trk_sel_off(W, NUM_LES, s, i);
            localparam int unsigned MOFF = mode_off(W, NUM_LES, s, i);

            sb_track_mux #(.N(TRK_N), .SEL_W(SB_SEL)) u_trk (
                .data ({a_c[s][i], b_c[s][i], c_c[s][i], data_from_les}),
                .sel  (cfg[SOFF +: SB_SEL]),
                .y_c  (trk_mux_c[s][i])
            );

            assign trk_out_c[s][i] = config_valid & (cfg[MOFF] ? trk_q[s][i] : trk_mux_c[s][i]);
        end
    end

    assign le_bus_c = {data_north_in, data_east_in, data_south_in, data_west_in, data_from_les};

    for (genvar k = 0; k < NUM_LES; k++) begin : g_le
        for (genvar j = 0; j < LE_INPUTS; j++) begin : g_pin
            localparam int unsigned LOFF = le_sel_off(W, NUM_LES, LE_INPUTS, k, j);

            sb_track_mux #(.N(LE_N), .SEL_W(LE_SEL)) u_le (
                .data (le_bus_c),
                .sel  (cfg[LOFF +: LE_SEL]),
                .y_c  (le_mux_c[k * LE_INPUTS + j])
            );
        end
    end

    assign data_north_out = trk_out_c[0];
    assign data_east_out  = trk_out_c[1];
    assign data_south_out = trk_out_c[2];
    assign data_west_out  = trk_out_c[3];
    assign data_to_les    = config_valid ? le_mux_c : '0;

endmodule

// File: tb/tb_switch_box_cfg.sv
// Directed self-checking bench for switch_box_cfg at default parameters
// (6 tracks, 2 LEs x 4 inputs, 136-bit config image).
module tb_switch_box_cfg;

    logic         clock = 1'b0;
    logic         reset;
    logic [5:0]   data_north_in, data_east_in, data_south_in, data_west_in;
    logic [5:0]   data_north_out, data_east_out, data_south_out, data_west_out;
    logic [1:0]   data_from_les;
    logic [7:0]   data_to_les;
    logic         config_in, config_enable, config_out, config_valid;

    int           n_checks = 0;
    int           n_pass   = 0;
    logic [135:0] img;
    logic [135:0] s1, s2, got;
    logic         seen_valid;

    always #5 clock = ~clock;

    switch_box_cfg #(.CHANNEL_WIDTH(6), .NUM_LES(2), .LE_INPUTS(4)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_north_in  (data_north_in),
        .data_east_in   (data_east_in),
        .data_south_in  (data_south_in),
        .data_west_in   (data_west_in),
        .data_north_out (data_north_out),
        .data_east_out  (data_east_out),
        .data_south_out (data_south_out),
        .data_west_out  (data_west_out),
        .data_from_les  (data_from_les),
        .data_to_les    (data_to_les),
        .config_in      (config_in),
        .config_enable  (config_enable),
        .config_out     (config_out),
        .config_valid   (config_valid)
    );

    task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [5:0] n, input logic [5:0] e,
                              input logic [5:0] s, input logic [5:0] w, input logic [7:0] le);
        check({tag, ".north"}, 136'(data_north_out), 136'(n));
        check({tag, ".east"},  136'(data_east_out),  136'(e));
        check({tag, ".south"}, 136'(data_south_out), 136'(s));
        check({tag, ".west"},  136'(data_west_out),  136'(w));
        check({tag, ".les"},   136'(data_to_les),    136'(le));
    endtask

    // Shift an image in MSB first so that it ends up bit-for-bit in the register.
    task automatic load(input logic [135:0] v);
        logic [135:0] t;
        t = v;
        config_enable = 1'b1;
        for (int b = 0; b < 136; b++) begin
            config_in = t[135];
            t = t << 1;
            tick();
        end
        config_enable = 1'b0;
        config_in     = 1'b0;
        #1;
    endtask

    // Field layout at defaults: track selects 3 bits from 0, modes from 72, LE selects 5 bits from 96.
    task automatic set_trk(input int side, input int t, input logic [2:0] sel);
        int off;
        off = (side * 6 + t) * 3;
        img = (img & ~(136'(7) << off)) | (136'(sel) << off);
    endtask

    task automatic set_mode(input int side, input int t, input logic m);
        int off;
        off = 72 + side * 6 + t;
        img = (img & ~(136'(1) << off)) | (136'(m) << off);
    endtask

    task automatic set_le(input int k, input int j, input logic [4:0] sel);
        int off;
        off = 96 + (k * 4 + j) * 5;
        img = (img & ~(136'(31) << off)) | (136'(sel) << off);
    endtask

    task automatic set_ins(input logic [5:0] n, input logic [5:0] e, input logic [5:0] s,
                           input logic [5:0] w, input logic [1:0] les);
        data_north_in = n;
        data_east_in  = e;
        data_south_in = s;
        data_west_in  = w;
        data_from_les = les;
    endtask

    initial begin
        reset = 1'b1;
        config_in = 1'b0;
        config_enable = 1'b0;
        set_ins(6'h3F, 6'h3F, 6'h3F, 6'h3F, 2'b11);
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("rst_valid", 136'(config_valid), 136'(0));
        check("rst_cfg_out", 136'(config_out), 136'(0));
        check_outs("rst_iso", 6'h00, 6'h00, 6'h00, 6'h00, 8'h00);

        // Chain passthrough: second stream pushes the first out of config_out.
        s1 = 136'hA5_0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        s2 = 136'h3C_DEAD_BEEF_0F0F_F0F0_1357_9BDF_2468_ACE0;
        load(s1);
        check("load1_valid", 136'(config_valid), 136'(1));
        check("load1_msb", 136'(config_out), 136'(s1[135]));
        got = '0;
        seen_valid = 1'b0;
        config_enable = 1'b1;
        begin
            logic [135:0] t;
            t = s2;
            for (int b = 0; b < 136; b++) begin
                config_in = t[135];
                t = t << 1;
                #1;
                got = {got[134:0], config_out};
                seen_valid = seen_valid | config_valid;
                tick();
            end
        end
        config_enable = 1'b0;
        #1;
        check("chain_replay", got, s1);
        check("valid_during_shift", 136'(seen_valid), 136'(0));
        check("load2_valid", 136'(config_valid), 136'(1));

        // Wilton mapping, north track 2: select A then B.
        img = '0;
        set_trk(0, 2, 3'd4);
        set_ins(6'h00, 6'h00, 6'h00, 6'b001000, 2'b00);
        load(img);
        check_outs("wilton_a", 6'b000100, 6'h00, 6'h00, 6'h00, 8'h00);
        data_from_les = 2'b01;
        #1;
        check_outs("wilton_a_les", 6'h3F, 6'h3F, 6'h3F, 6'h3F, 8'hFF);
        set_ins(6'h00, 6'h00, 6'b000100, 6'h00, 2'b00);
        #1;
        check("wilton_a_off", 136'(data_north_out), 136'(0));
        img = '0;
        set_trk(0, 2, 3'd3);
        load(img);
        check("wilton_b", 136'(data_north_out), 136'(6'b000100));
        data_south_in = 6'h00;
        #1;
        check("wilton_b_off", 136'(data_north_out), 136'(0));

        // Register mode on east track 0 (C = south[1]).
        img = '0;
        set_trk(1, 0, 3'd2);
        set_mode(1, 0, 1'b1);
        set_ins(6'h00, 6'h00, 6'b000010, 6'h00, 2'b00);
        load(img);
        check("reg_first_valid", 136'(data_east_out), 136'(0));
        tick();
        check("reg_first_value", 136'(data_east_out), 136'(6'b000001));
        data_south_in = 6'h00;
        #1;
        check("reg_hold", 136'(data_east_out), 136'(6'b000001));
        tick();
        check("reg_fall", 136'(data_east_out), 136'(0));
        data_south_in = 6'b000010;
        #1;
        check("reg_n", 136'(data_east_out), 136'(0));
        tick();
        check("reg_n1", 136'(data_east_out), 136'(6'b000001));
        set_mode(1, 0, 1'b0);
        data_south_in = 6'h00;
        load(img);
        check("comb_idle", 136'(data_east_out), 136'(0));
        data_south_in = 6'b000010;
        #1;
        check("comb_n", 136'(data_east_out), 136'(6'b000001));

        // LE mux: LE 1 input 3 follows north[5].
        img = '0;
        set_le(1, 3, 5'd25);
        set_ins(6'h00, 6'h00, 6'h00, 6'h00, 2'b00);
        load(img);
        data_north_in = 6'b100000;
        #1;
        check("le_north5_hi", 136'(data_to_les), 136'(8'h80));
        data_north_in = 6'h00;
        #1;
        check("le_north5_lo", 136'(data_to_les), 136'(8'h00));

        // Out-of-range selects on LE and track muxes yield 0.
        for (int v = 26; v < 32; v++) begin
            img = '0;
            set_le(1, 3, 5'(v));
            set_trk(0, 0, 3'(5 + v % 3));
            set_trk(1, 2, 3'd6);
            set_trk(3, 5, 3'd7);
            set_ins(6'h3F, 6'h3F, 6'h3F, 6'h3F, 2'b11);
            load(img);
            check_outs($sformatf("oor_%0d", v), 6'b111110, 6'b111011, 6'h3F, 6'b011111, 8'h7F);
        end

        // Isolation during a single-cycle reshift, new config live the next cycle.
        img = '0;
        set_ins(6'h00, 6'h00, 6'h00, 6'h00, 2'b01);
        load(img);
        check_outs("reshift_pre", 6'h3F, 6'h3F, 6'h3F, 6'h3F, 8'hFF);
        config_enable = 1'b1;
        config_in = 1'b1;
        #1;
        check("reshift_valid", 136'(config_valid), 136'(0));
        check_outs("reshift_iso", 6'h00, 6'h00, 6'h00, 6'h00, 8'h00);
        tick();
        config_enable = 1'b0;
        config_in = 1'b0;
        #1;
        check("reshift_valid_back", 136'(config_valid), 136'(1));
        check_outs("reshift_new", 6'b111110, 6'h3F, 6'h3F, 6'h3F, 8'hFF);

        // Reset mid-operation, together with a shift, and mid-load.
        load(s1);
        reset = 1'b1;
        config_enable = 1'b1;
        config_in = 1'b1;
        tick();
        check("rst_en_cfg_out", 136'(config_out), 136'(0));
        config_enable = 1'b0;
        #1;
        check("rst_mid_valid", 136'(config_valid), 136'(0));
        check_outs("rst_mid_iso", 6'h00, 6'h00, 6'h00, 6'h00, 8'h00);
        tick();
        reset = 1'b0;
        #1;
        check("rst_release_valid", 136'(config_valid), 136'(0));
        config_enable = 1'b1;
        config_in = 1'b0;
        for (int b = 0; b < 50; b++) tick();
        config_enable = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        config_enable = 1'b1;
        for (int b = 0; b < 86; b++) tick();
        config_enable = 1'b0;
        #1;
        check("partial_discarded", 136'(config_valid), 136'(0));
        config_enable = 1'b1;
        for (int b = 0; b < 50; b++) tick();
        config_enable = 1'b0;
        #1;
        check("fresh_load_valid", 136'(config_valid), 136'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
